// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the MEM pipeline stage: memory op codes,
//            FSM state encoding, access-size classification helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

   // Memory op codes carried on ALU_Control1_IN
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   // Any code that is not a byte or halfword op is handled as a full word;
   // the direction comes from MemRead/MemWrite, not from the code.
   function automatic mem_size_t op_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
         default:              op_size = SZ_WORD;
      endcase
   endfunction

   function automatic logic op_signed(input logic [5:0] op);
      op_signed = (op == OP_LB) || (op == OP_LH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Combinational big-endian lane logic. Produces store byte enables
//            and replicated store data, extracts and extends load data from a
//            returned word, and flags misaligned halfword/word accesses.
// Ports    : i_op          memory op code
//            i_addr_lo     effective address bits [1:0]
//            i_store_data  raw store data
//            i_load_word   word returned by data memory
//            o_be          byte enables, bit 3 = lane [31:24]
//            o_wdata       lane-replicated store data
//            o_load_data   extracted and extended load result
//            o_misaligned  access violates its natural alignment
// Revision : 1.0 - initial release
// ============================================================================
module mem_align (
   input  logic [5:0]  i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_load_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data,
   output logic        o_misaligned
);
   import mem_pkg::*;

   mem_size_t   w_size;
   logic        w_signed;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_size       = op_size(i_op);
      w_signed     = op_signed(i_op);
      o_be         = 4'b1111;
      o_wdata      = i_store_data;
      o_load_data  = i_load_word;
      o_misaligned = 1'b0;
      w_byte       = 8'h00;

      // Big-endian: offset 0 is the most significant byte lane
      case (i_addr_lo)
         2'd0:    w_byte = i_load_word[31:24];
         2'd1:    w_byte = i_load_word[23:16];
         2'd2:    w_byte = i_load_word[15:8];
         default: w_byte = i_load_word[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_load_word[15:0] : i_load_word[31:16];

      case (w_size)
         SZ_BYTE: begin
            o_be        = 4'b1000 >> i_addr_lo;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_be         = i_addr_lo[1] ? 4'b0011 : 4'b1100;
            o_wdata      = {2{i_store_data[15:0]}};
            o_load_data  = {{16{w_signed & w_half[15]}}, w_half};
            o_misaligned = i_addr_lo[0];
         end
         default: begin
            o_misaligned = (i_addr_lo != 2'b00);
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Single-issue MEM pipeline stage. Issues data-memory loads and
//            stores over a req/ack port, formats load results, stalls EXE
//            while an access is outstanding and passes non-memory
//            instructions to the WB register with one cycle of latency.
// Params   : ADDR_W       data-memory address width (<= 32)
//            TIMEOUT_CYC  BUSY cycles without ack before abandoning the
//                         access with a fault; 0 disables the timeout
// Ports    : CLK, RESET (async, active low)
//            *_IN         EXE pipeline register contents
//            dmem_*       data-memory request/acknowledge port
//            STALL_fMEM   hold request to EXE
//            *_OUT        WB pipeline register
// Options  : MEM_BYPASS_EN adds BypassReg1/BypassData1/BypassValid1_MEMEXE
//            forwarding outputs driven from the WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       Instr1_IN,
   input  logic [31:0]       Instr1_PC_IN,
   input  logic [31:0]       ALU_result1_IN,
   input  logic [4:0]        WriteRegister1_IN,
   input  logic [31:0]       MemWriteData1_IN,
   input  logic              RegWrite1_IN,
   input  logic              MemRead1_IN,
   input  logic              MemWrite1_IN,
   input  logic [5:0]        ALU_Control1_IN,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              STALL_fMEM,
   output logic [31:0]       Instr1_OUT,
   output logic [31:0]       Instr1_PC_OUT,
   output logic [31:0]       WriteData1_OUT,
   output logic [4:0]        WriteRegister1_OUT,
   output logic              RegWrite1_OUT,
   output logic              MemFault1_OUT
`ifdef MEM_BYPASS_EN
  ,output logic [4:0]        BypassReg1_MEMEXE,
   output logic [31:0]       BypassData1_MEMEXE,
   output logic              BypassValid1_MEMEXE
`endif
);
   import mem_pkg::*;

   localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_to_last =
      (TIMEOUT_CYC > 0) ? c_cnt_w'(TIMEOUT_CYC - 1) : '0;
   localparam logic c_to_en = (TIMEOUT_CYC > 0);

   mem_state_t         r_state;
   mem_state_t         w_state_nxt;
   logic               w_mem_op;
   logic               w_misaligned;
   logic               w_mis_fault;
   logic               w_start;
   logic               w_ack_hit;
   logic               w_to_hit;
   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_rdata;
   logic               r_to_fault;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic [31:0]        w_load_data;

   // One lane unit serves both paths: in IDLE it shapes the store request,
   // in DONE it formats the held read data. EXE holds its outputs across the
   // whole access, so the live op code and address are valid in both.
   mem_align u_align (
      .i_op         (ALU_Control1_IN),
      .i_addr_lo    (ALU_result1_IN[1:0]),
      .i_store_data (MemWriteData1_IN),
      .i_load_word  (r_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data),
      .o_misaligned (w_misaligned)
   );

   assign w_mem_op    = MemRead1_IN | MemWrite1_IN;
   assign w_mis_fault = w_mem_op & w_misaligned;
   // Dropping the stall in DONE lets EXE advance on the same edge that
   // writes the formatted result into the WB register.
   assign STALL_fMEM  = w_mem_op & ~w_misaligned & (r_state != ST_DONE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_ack_hit   = 1'b0;
      w_to_hit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_mem_op && !w_misaligned) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (dmem_ack) begin
               w_ack_hit   = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (c_to_en && (r_cnt == c_to_last)) begin
               w_to_hit    = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------ request port and hold regs
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= 4'b0000;
         dmem_wdata <= 32'h0;
         r_cnt      <= '0;
         r_rdata    <= 32'h0;
         r_to_fault <= 1'b0;
      end else if (w_start) begin
         dmem_req   <= 1'b1;
         dmem_we    <= MemWrite1_IN;
         dmem_addr  <= {ALU_result1_IN[ADDR_W-1:2], 2'b00};
         dmem_be    <= w_be;
         dmem_wdata <= w_wdata;
         r_cnt      <= '0;
         r_to_fault <= 1'b0;
      end else if (r_state == ST_BUSY) begin
         r_cnt <= r_cnt + c_cnt_w'(1);
         if (w_ack_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            r_rdata  <= dmem_rdata;
         end else if (w_to_hit) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            r_rdata    <= 32'h0;
            r_to_fault <= 1'b1;
         end
      end
   end

   // ------------------------------------------------- WB pipeline register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Instr1_OUT         <= 32'h0;
         Instr1_PC_OUT      <= 32'h0;
         WriteData1_OUT     <= 32'h0;
         WriteRegister1_OUT <= 5'd0;
         RegWrite1_OUT      <= 1'b0;
         MemFault1_OUT      <= 1'b0;
      end else if (STALL_fMEM) begin
         Instr1_OUT         <= 32'h0;
         Instr1_PC_OUT      <= 32'h0;
         WriteData1_OUT     <= 32'h0;
         WriteRegister1_OUT <= 5'd0;
         RegWrite1_OUT      <= 1'b0;
         MemFault1_OUT      <= 1'b0;
      end else if (r_state == ST_DONE) begin
         Instr1_OUT         <= Instr1_IN;
         Instr1_PC_OUT      <= Instr1_PC_IN;
         WriteData1_OUT     <= MemWrite1_IN ? ALU_result1_IN : w_load_data;
         WriteRegister1_OUT <= WriteRegister1_IN;
         RegWrite1_OUT      <= RegWrite1_IN & ~MemWrite1_IN & ~r_to_fault;
         MemFault1_OUT      <= r_to_fault;
      end else begin
         // Plain pass-through; a misaligned memory op also lands here,
         // with write-back suppressed and the fault raised.
         Instr1_OUT         <= Instr1_IN;
         Instr1_PC_OUT      <= Instr1_PC_IN;
         WriteData1_OUT     <= ALU_result1_IN;
         WriteRegister1_OUT <= WriteRegister1_IN;
         RegWrite1_OUT      <= RegWrite1_IN & ~w_mis_fault;
         MemFault1_OUT      <= w_mis_fault;
      end
   end

`ifdef MEM_BYPASS_EN
   assign BypassReg1_MEMEXE   = WriteRegister1_OUT;
   assign BypassData1_MEMEXE  = WriteData1_OUT;
   assign BypassValid1_MEMEXE = RegWrite1_OUT & ~MemFault1_OUT;
`else
   // No forwarding outputs in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage (TIMEOUT_CYC = 4). Table of
//            directed vectors with hand-computed results, plus hand-written
//            reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
   import mem_pkg::*;

   logic        CLK, RESET;
   logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
   logic [4:0]  WriteRegister1_IN;
   logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
   logic [5:0]  ALU_Control1_IN;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        STALL_fMEM;
   logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
   logic [4:0]  WriteRegister1_OUT;
   logic        RegWrite1_OUT, MemFault1_OUT;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
      .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
      .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
      .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
      .ALU_Control1_IN(ALU_Control1_IN),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .STALL_fMEM(STALL_fMEM),
      .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
      .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
      .RegWrite1_OUT(RegWrite1_OUT), .MemFault1_OUT(MemFault1_OUT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [5:0]  op;
      logic        rd, wr, rw;
      logic [31:0] alu, mdata;
      logic [4:0]  wreg;
      int          ack_dly;   // BUSY cycle (1-based) carrying the ack; 0 = never
      logic [31:0] rdata;
      int          e_stall, e_busy;
      logic        e_rw, e_fault, chk_wd;
      logic [31:0] e_wd;
      logic [3:0]  e_be;
      logic [31:0] e_mwd;
   } vec_t;

   function automatic vec_t mk(
      input logic [5:0] op, input logic rd, input logic wr, input logic rw,
      input logic [31:0] alu, input logic [31:0] mdata, input logic [4:0] wreg,
      input int ack_dly, input logic [31:0] rdata, input int e_stall,
      input int e_busy, input logic e_rw, input logic e_fault,
      input logic chk_wd, input logic [31:0] e_wd, input logic [3:0] e_be,
      input logic [31:0] e_mwd);
      vec_t v;
      v.op = op; v.rd = rd; v.wr = wr; v.rw = rw; v.alu = alu; v.mdata = mdata;
      v.wreg = wreg; v.ack_dly = ack_dly; v.rdata = rdata;
      v.e_stall = e_stall; v.e_busy = e_busy; v.e_rw = e_rw;
      v.e_fault = e_fault; v.chk_wd = chk_wd; v.e_wd = e_wd;
      v.e_be = e_be; v.e_mwd = e_mwd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          stall_cnt, busy_cnt;
      logic [31:0] cap_addr, cap_wd;
      logic [3:0]  cap_be;
      logic        cap_we, bubble_ok;
      Instr1_IN         = 32'hC0DE_0000 | idx;
      Instr1_PC_IN      = 32'h0000_1000 + 32'(idx * 4);
      ALU_result1_IN    = v.alu;
      WriteRegister1_IN = v.wreg;
      MemWriteData1_IN  = v.mdata;
      RegWrite1_IN      = v.rw;
      MemRead1_IN       = v.rd;
      MemWrite1_IN      = v.wr;
      ALU_Control1_IN   = v.op;
      stall_cnt = 0; busy_cnt = 0; bubble_ok = 1'b1;
      cap_addr = 32'h0; cap_wd = 32'h0; cap_be = 4'h0; cap_we = 1'b0;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (!STALL_fMEM) break;
         stall_cnt++;
         if (c > 0 && (RegWrite1_OUT || MemFault1_OUT || Instr1_OUT != 32'h0))
            bubble_ok = 1'b0;
         if (dmem_req) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
               cap_addr = dmem_addr; cap_wd = dmem_wdata;
               cap_be = dmem_be; cap_we = dmem_we;
            end
         end
         dmem_ack   = dmem_req && (busy_cnt == v.ack_dly);
         dmem_rdata = dmem_ack ? v.rdata : 32'h0BAD_0BAD;
         @(posedge CLK); #2;
         dmem_ack = 1'b0;
      end
      @(posedge CLK); #2;
      chk($sformatf("v%0d.stall_cycles", idx), 32'(stall_cnt), 32'(v.e_stall));
      chk($sformatf("v%0d.busy_cycles", idx), 32'(busy_cnt), 32'(v.e_busy));
      if (stall_cnt > 1)
         chk($sformatf("v%0d.bubble", idx), {31'd0, bubble_ok}, 32'd1);
      chk($sformatf("v%0d.regwrite", idx), {31'd0, RegWrite1_OUT}, {31'd0, v.e_rw});
      chk($sformatf("v%0d.fault", idx), {31'd0, MemFault1_OUT}, {31'd0, v.e_fault});
      chk($sformatf("v%0d.wreg", idx), {27'd0, WriteRegister1_OUT}, {27'd0, v.wreg});
      chk($sformatf("v%0d.instr", idx), Instr1_OUT, 32'hC0DE_0000 | idx);
      chk($sformatf("v%0d.pc", idx), Instr1_PC_OUT, 32'h0000_1000 + 32'(idx * 4));
      chk($sformatf("v%0d.req_idle", idx), {31'd0, dmem_req}, 32'd0);
      if (v.chk_wd)
         chk($sformatf("v%0d.wdata_out", idx), WriteData1_OUT, v.e_wd);
      if (v.e_busy > 0) begin
         chk($sformatf("v%0d.dmem_addr", idx), cap_addr, v.alu & 32'hFFFF_FFFC);
         chk($sformatf("v%0d.dmem_we", idx), {31'd0, cap_we}, {31'd0, v.wr});
         if (v.wr) begin
            chk($sformatf("v%0d.dmem_be", idx), {28'd0, cap_be}, {28'd0, v.e_be});
            chk($sformatf("v%0d.dmem_wdata", idx), cap_wd, v.e_mwd);
         end
      end
   endtask

   vec_t vecs[16];

   initial begin
      //                op      rd wr rw alu           mdata         wreg ack rdata         stl bsy rw flt cwd e_wd          be       mwd
      vecs[0]  = mk(6'h00,  0, 0, 1, 32'h0000_1234, 32'h0,        5,  0, 32'h0,         0, 0, 1, 0, 1, 32'h0000_1234, 4'h0,    32'h0);
      vecs[1]  = mk(OP_LB,  1, 0, 1, 32'h0000_1001, 32'h0,        7,  2, 32'h11F2_3344, 3, 2, 1, 0, 1, 32'hFFFF_FFF2, 4'h0,    32'h0);
      vecs[2]  = mk(OP_LBU, 1, 0, 1, 32'h0000_1001, 32'h0,        7,  2, 32'h11F2_3344, 3, 2, 1, 0, 1, 32'h0000_00F2, 4'h0,    32'h0);
      vecs[3]  = mk(OP_SH,  0, 1, 1, 32'h0000_2002, 32'hABCD_1234, 9, 1, 32'h0,         2, 1, 0, 0, 0, 32'h0,         4'b0011, 32'h1234_1234);
      vecs[4]  = mk(OP_LW,  1, 0, 1, 32'h0000_3002, 32'h0,        10, 1, 32'h0,         0, 0, 0, 1, 1, 32'h0000_3002, 4'h0,    32'h0);
      vecs[5]  = mk(OP_LH,  1, 0, 1, 32'h0000_4000, 32'h0,        11, 1, 32'h8001_7FFE, 2, 1, 1, 0, 1, 32'hFFFF_8001, 4'h0,    32'h0);
      vecs[6]  = mk(OP_LHU, 1, 0, 1, 32'h0000_4002, 32'h0,        12, 1, 32'h1234_F00D, 2, 1, 1, 0, 1, 32'h0000_F00D, 4'h0,    32'h0);
      vecs[7]  = mk(OP_LW,  1, 0, 1, 32'h0000_5000, 32'h0,        13, 3, 32'hDEAD_BEEF, 4, 3, 1, 0, 1, 32'hDEAD_BEEF, 4'h0,    32'h0);
      vecs[8]  = mk(OP_SB,  0, 1, 0, 32'h0000_6003, 32'h0000_00A5, 0, 1, 32'h0,         2, 1, 0, 0, 0, 32'h0,         4'b0001, 32'hA5A5_A5A5);
      vecs[9]  = mk(OP_SW,  0, 1, 0, 32'h0000_7004, 32'hCAFE_F00D, 0, 1, 32'h0,         2, 1, 0, 0, 0, 32'h0,         4'b1111, 32'hCAFE_F00D);
      vecs[10] = mk(OP_LH,  1, 0, 1, 32'h0000_8001, 32'h0,        14, 1, 32'h0,         0, 0, 0, 1, 1, 32'h0000_8001, 4'h0,    32'h0);
      vecs[11] = mk(6'h3F,  1, 0, 1, 32'h0000_9000, 32'h0,        15, 1, 32'h0102_0304, 2, 1, 1, 0, 1, 32'h0102_0304, 4'h0,    32'h0);
      vecs[12] = mk(OP_LB,  1, 0, 1, 32'h0000_A000, 32'h0,        16, 0, 32'h0,         5, 4, 0, 1, 0, 32'h0,         4'h0,    32'h0);
      vecs[13] = mk(OP_LB,  1, 0, 1, 32'h0000_B003, 32'h0,        17, 1, 32'h0000_0080, 2, 1, 1, 0, 1, 32'hFFFF_FF80, 4'h0,    32'h0);
      vecs[14] = mk(6'h00,  0, 0, 0, 32'hFFFF_0000, 32'h0,        31, 0, 32'h0,         0, 0, 0, 0, 1, 32'hFFFF_0000, 4'h0,    32'h0);
      vecs[15] = mk(OP_SB,  0, 1, 0, 32'h0000_C000, 32'h0000_005A, 3, 1, 32'h0,         2, 1, 0, 0, 0, 32'h0,         4'b1000, 32'h5A5A_5A5A);

      RESET = 1'b1;
      Instr1_IN = 32'h0; Instr1_PC_IN = 32'h0; ALU_result1_IN = 32'h0;
      WriteRegister1_IN = 5'd0; MemWriteData1_IN = 32'h0; RegWrite1_IN = 1'b0;
      MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0; ALU_Control1_IN = 6'h00;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      #1 RESET = 1'b0;

      // Reset state
      @(posedge CLK); #2;
      @(posedge CLK); #2;
      chk("rst.wdata", WriteData1_OUT, 32'h0);
      chk("rst.regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
      chk("rst.fault", {31'd0, MemFault1_OUT}, 32'd0);
      chk("rst.instr", Instr1_OUT, 32'h0);
      chk("rst.req", {31'd0, dmem_req}, 32'd0);
      chk("rst.stall", {31'd0, STALL_fMEM}, 32'd0);
      RESET = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // Reset in the middle of an access
      Instr1_IN = 32'h1111_2222; Instr1_PC_IN = 32'h0000_0400;
      ALU_result1_IN = 32'h0000_0100; WriteRegister1_IN = 5'd4;
      RegWrite1_IN = 1'b1; MemRead1_IN = 1'b1; MemWrite1_IN = 1'b0;
      ALU_Control1_IN = OP_LW;
      @(posedge CLK); #2;
      chk("mid.req_busy", {31'd0, dmem_req}, 32'd1);
      #1 RESET = 1'b0;
      #1;
      chk("mid.req_async", {31'd0, dmem_req}, 32'd0);
      chk("mid.regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
      chk("mid.instr", Instr1_OUT, 32'h0);
      ALU_result1_IN = 32'h0; WriteRegister1_IN = 5'd0; RegWrite1_IN = 1'b0;
      MemRead1_IN = 1'b0; ALU_Control1_IN = 6'h00; Instr1_IN = 32'h0;
      Instr1_PC_IN = 32'h0;
      @(posedge CLK); #2;
      RESET = 1'b1;
      // Stray ack after reset must be ignored
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(posedge CLK); #2;
      dmem_ack = 1'b0;
      chk("stray.req", {31'd0, dmem_req}, 32'd0);
      chk("stray.stall", {31'd0, STALL_fMEM}, 32'd0);
      @(posedge CLK); #2;
      chk("stray.wdata", WriteData1_OUT, 32'h0);
      chk("stray.regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
      chk("stray.fault", {31'd0, MemFault1_OUT}, 32'd0);
      // FSM must be back in IDLE: a fresh load takes the minimum latency
      run_vec(mk(OP_LW, 1, 0, 1, 32'h0000_0200, 32'h0, 6, 1, 32'h7654_3210,
                 2, 1, 1, 0, 1, 32'h7654_3210, 4'h0, 32'h0), 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Single-issue MEM stage; sits directly downstream of the EXE stage and consumes its pipeline registers.
- Performs data-memory loads and stores through a request/acknowledge port, with big-endian byte/halfword alignment and sign/zero extension.
- Stalls EXE through STALL_fMEM while an access is outstanding.
- Non-memory instructions pass through to the WB pipeline register with one cycle of latency.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYC, 255, BUSY cycles without dmem_ack before the access is abandoned and flagged; 0 disables the timeout.

Ports:
- CLK  in  1  stage clock.
- RESET  in  1  asynchronous, active-low reset.
- Instr1_IN, Instr1_PC_IN  in  32 each  debug instruction word and PC from EXE.
- ALU_result1_IN  in  32  ALU result; also the effective address for memory ops.
- WriteRegister1_IN  in  5  destination register.
- MemWriteData1_IN  in  32  store data.
- RegWrite1_IN, MemRead1_IN, MemWrite1_IN  in  1 each  EXE control.
- ALU_Control1_IN  in  6  memory op code.
- dmem_req  out  1  access request.
- dmem_we  out  1  write request.
- dmem_addr  out  ADDR_W  word-aligned address, low two bits forced to 0.
- dmem_wdata  out  32  store data.
- dmem_be  out  4  byte enables; bit 3 is byte lane [31:24].
- dmem_ack  in  1  access complete.
- dmem_rdata  in  32  read data, valid in the ack cycle.
- STALL_fMEM  out  1  EXE must hold its outputs.
- Instr1_OUT, Instr1_PC_OUT  out  32 each  debug outputs to WB.
- WriteData1_OUT  out  32  value to be written back.
- WriteRegister1_OUT  out  5  destination register to WB.
- RegWrite1_OUT  out  1  write-back enable.
- MemFault1_OUT  out  1  misaligned access or timeout.

Behaviour:
- Reset: all registered outputs are 0, FSM is IDLE, and dmem_req is deasserted immediately (asynchronously).
- On reset mid-access, any dmem_ack that arrives afterwards is ignored.
- mem_op = MemRead1_IN | MemWrite1_IN.
- Alignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is misaligned.
  - No request is issued.
  - One-cycle pass-through with RegWrite1_OUT=0 and MemFault1_OUT=1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if mem_op and aligned, go to BUSY; otherwise load the WB register from the inputs (WriteData1_OUT = ALU_result1_IN).
  - BUSY: dmem_req=1. On dmem_ack, capture dmem_rdata into a hold register and go to DONE. After TIMEOUT_CYC cycles without ack, go to DONE with fault=1.
  - DONE: load the WB register with the formatted result. For stores, RegWrite1_OUT=0. Next state is IDLE.
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable for the whole of BUSY.
- STALL_fMEM = mem_op & aligned & (state≠DONE), combinational.
  - Minimum memory-op latency: 3 cycles (IDLE, BUSY+ack, DONE).
  - An ack in the first BUSY cycle is legal.
  - Back-to-back memory ops each return through IDLE.
- While STALL_fMEM=1, the WB register loads a bubble: RegWrite1_OUT=0, Instr1_OUT=0, MemFault1_OUT=0.
- Loads (big-endian, o = addr[1:0]):
  - LB/LBU select byte lane 3−o and sign- or zero-extend it.
  - LH/LHU select [31:16] when addr[1]=0, else [15:0].
  - LW passes the word through.
- Stores:
  - SB: be = 4'b1000>>o, wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b0011 : 4'b1100, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
- An unrecognised ALU_Control1_IN with mem_op=1 is treated as LW/SW by direction.

Optional Feature:
- Macro: MEM_BYPASS_EN.
- When defined, the block adds three outputs to EXE's forwarding logic, all driven from the WB register and zero at reset:
  - BypassReg1_MEMEXE[4:0] = WriteRegister1_OUT.
  - BypassData1_MEMEXE[31:0] = WriteData1_OUT.
  - BypassValid1_MEMEXE = RegWrite1_OUT & ~MemFault1_OUT.
- When undefined, these ports do not exist.

Decomposition:
- Shared package mem_pkg holds the op codes LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B, and the FSM state encoding.
- One sub-module, mem_align: combinational store lane/byte-enable generation and load extract/extend, shared between the request path and the DONE path.

Test Plan:
- ALU op, RegWrite1_IN=1, result 0x1234 to r5 -> next cycle WriteData1_OUT=0x1234, WriteRegister1_OUT=5, RegWrite1_OUT=1, STALL_fMEM never high.
- LB at 0x1001, ack after 2 cycles with rdata 0x11F23344 -> STALL_fMEM high for 3 cycles, dmem_addr=0x1000, WriteData1_OUT=0xFFFFFFF2; the same case with LBU gives 0x000000F2.
- SH at 0x2002, data 0xABCD1234 -> dmem_we=1, dmem_be=4'b0011, dmem_wdata=0x12341234, RegWrite1_OUT=0 in DONE.
- LW at 0x3002 -> no dmem_req, MemFault1_OUT=1 for one cycle, no stall.
- Access with no ack and TIMEOUT_CYC=4 -> exactly 4 BUSY cycles, then DONE with MemFault1_OUT=1, RegWrite1_OUT=0.
- RESET low during BUSY -> dmem_req drops asynchronously, outputs go to 0, FSM is IDLE, and a later stray dmem_ack produces no write-back.
